// File: rtl/pagerank_iteration_controller_if.sv
// pagerank_iteration_controller_if
// Groups the host command/status signals and the partition-engine handshake
// of the PageRank iteration controller into one bundle.
//
// Signals:
//   start, threshold, max_iter      host -> controller, run command
//   busy, pagerank_complete,
//   converged, iteration_number,
//   delta                           controller -> host, run status
//   part_start, part_id,
//   swap_buffers                    controller -> engine, partition commands
//   part_done, part_delta           engine -> controller, partition result
//
// Modports:
//   master : the controller
//   slave  : the host/engine side that commands the controller and serves it
interface pagerank_iteration_controller_if #(
  parameter int NUM_PARTITIONS = 11,
  parameter int DELTA_W        = 32,
  parameter int ITER_W         = 16
);
  localparam int PART_W = ($clog2(NUM_PARTITIONS) > 0) ? $clog2(NUM_PARTITIONS) : 1;

  logic               start;
  logic [DELTA_W-1:0] threshold;
  logic [ITER_W-1:0]  max_iter;
  logic               part_start;
  logic [PART_W-1:0]  part_id;
  logic               part_done;
  logic [DELTA_W-1:0] part_delta;
  logic               swap_buffers;
  logic               busy;
  logic               pagerank_complete;
  logic               converged;
  logic [ITER_W-1:0]  iteration_number;
  logic [DELTA_W-1:0] delta;

  modport master (
    input  start, threshold, max_iter, part_done, part_delta,
    output part_start, part_id, swap_buffers, busy, pagerank_complete,
           converged, iteration_number, delta
  );

  modport slave (
    output start, threshold, max_iter, part_done, part_delta,
    input  part_start, part_id, swap_buffers, busy, pagerank_complete,
           converged, iteration_number, delta
  );
endinterface

// File: rtl/pagerank_iteration_controller.sv
// pagerank_iteration_controller
// Sequences PageRank iterations over NUM_PARTITIONS graph partitions. Each
// iteration issues every partition to an external engine, sums the engine's
// per-partition rank change (saturating), then either finishes (converged or
// iteration limit reached) or tells the engine to swap rank buffers and runs
// another iteration.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous, active-high
//   bus    pagerank_iteration_controller_if.master:
//            start/threshold/max_iter in, busy/pagerank_complete/converged/
//            iteration_number/delta out, part_start/part_id/swap_buffers out,
//            part_done/part_delta in
module pagerank_iteration_controller #(
  parameter int NUM_PARTITIONS = 11,
  parameter int DELTA_W        = 32,
  parameter int ITER_W         = 16
) (
  input logic                             clock,
  input logic                             reset,
  pagerank_iteration_controller_if.master bus
);
  localparam int PART_W = ($clog2(NUM_PARTITIONS) > 0) ? $clog2(NUM_PARTITIONS) : 1;
  localparam logic [PART_W-1:0]  LAST_PART = PART_W'(NUM_PARTITIONS - 1);
  localparam logic [DELTA_W-1:0] DELTA_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    SWAP,
    DONE
  } state_t;

  state_t             state;
  logic [DELTA_W-1:0] acc;
  logic [DELTA_W-1:0] thr;
  logic [ITER_W-1:0]  last_iter;
  logic [DELTA_W:0]   sum;

  // One extra bit catches the carry so the accumulator can clamp instead of wrap.
  always_comb sum = {1'b0, acc} + {1'b0, bus.part_delta};

  // Outputs are registered: each pulse/flag is set on the edge that enters the
  // state it belongs to, so part_start is high exactly during ISSUE and
  // swap_buffers exactly during SWAP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      acc                   <= '0;
      thr                   <= '0;
      last_iter             <= '0;
      bus.part_start        <= 1'b0;
      bus.part_id           <= '0;
      bus.swap_buffers      <= 1'b0;
      bus.busy              <= 1'b0;
      bus.pagerank_complete <= 1'b0;
      bus.converged         <= 1'b0;
      bus.iteration_number  <= '0;
      bus.delta             <= '0;
    end else begin
      bus.part_start   <= 1'b0;
      bus.swap_buffers <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            thr <= bus.threshold;
            // Store the index of the last allowed iteration; a limit of 0 acts as 1.
            last_iter <= (bus.max_iter == '0) ? '0 : bus.max_iter - ITER_W'(1);
            bus.iteration_number  <= '0;
            bus.part_id           <= '0;
            acc                   <= '0;
            bus.pagerank_complete <= 1'b0;
            bus.converged         <= 1'b0;
            bus.busy              <= 1'b1;
            bus.part_start        <= 1'b1;
            state                 <= ISSUE;
          end
        end

        ISSUE: begin
          state <= WAIT;
        end

        WAIT: begin
          if (bus.part_done) begin
            acc <= sum[DELTA_W] ? DELTA_MAX : sum[DELTA_W-1:0];
            if (bus.part_id == LAST_PART) begin
              state <= CHECK;
            end else begin
              bus.part_id    <= bus.part_id + PART_W'(1);
              bus.part_start <= 1'b1;
              state          <= ISSUE;
            end
          end
        end

        CHECK: begin
          bus.delta <= acc;
          if (acc < thr) begin
            bus.converged         <= 1'b1;
            bus.pagerank_complete <= 1'b1;
            bus.busy              <= 1'b0;
            state                 <= DONE;
          end else if (bus.iteration_number == last_iter) begin
            bus.converged         <= 1'b0;
            bus.pagerank_complete <= 1'b1;
            bus.busy              <= 1'b0;
            state                 <= DONE;
          end else begin
            bus.swap_buffers <= 1'b1;
            state            <= SWAP;
          end
        end

        SWAP: begin
          bus.iteration_number <= bus.iteration_number + ITER_W'(1);
          acc                  <= '0;
          bus.part_id          <= '0;
          bus.part_start       <= 1'b1;
          state                <= ISSUE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pagerank_iteration_controller.sv
// tb_pagerank_iteration_controller
// Self-checking bench: an engine model answers part_start with part_done after
// a random latency, taking per-partition deltas from a table; a behavioural
// model sums the table per iteration to predict the run outcome.
module tb_pagerank_iteration_controller;
  localparam int NP = 11;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int PW = $clog2(NP);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pagerank_iteration_controller_if #(.NUM_PARTITIONS(NP), .DELTA_W(DW), .ITER_W(IW)) bus ();
  pagerank_iteration_controller #(.NUM_PARTITIONS(NP), .DELTA_W(DW), .ITER_W(IW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  pagerank_iteration_controller_if #(.NUM_PARTITIONS(3), .DELTA_W(8), .ITER_W(4)) bus8 ();
  pagerank_iteration_controller #(.NUM_PARTITIONS(3), .DELTA_W(8), .ITER_W(4)) dut8 (
    .clock (clk),
    .reset (rst),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine delta table: [iteration][partition]
  logic [DW-1:0] tab [8][NP];

  // Observed run results
  int            r_cycles, r_swaps, r_starts, r_seq_err, r_overlap, r_busy_err;
  bit            r_timeout, r_aborted;
  logic [IW-1:0] r_first_iter;

  // Model predictions
  bit            m_conv;
  int            m_iter;
  logic [DW-1:0] m_delta;

  // Behavioural reference: plain arithmetic over the delta table.
  task automatic model_run(input logic [DW-1:0] thr, input logic [IW-1:0] mi);
    int     lim;
    longint acc;
    lim = (mi == 0) ? 1 : int'(mi);
    m_conv = 1'b0;
    m_iter = 0;
    m_delta = '0;
    for (int it = 0; it < lim && it < 8; it++) begin
      acc = 0;
      for (int p = 0; p < NP; p++) begin
        acc = acc + longint'(tab[it][p]);
        if (acc > 64'h0000_0000_FFFF_FFFF) acc = 64'h0000_0000_FFFF_FFFF;
      end
      m_delta = acc[31:0];
      m_iter = it;
      if (acc < longint'(thr)) begin
        m_conv = 1'b1;
        break;
      end
    end
  endtask

  // Starts a run and plays the engine until pagerank_complete, a cycle budget,
  // or (if abort_it >= 0) asserts reset in WAIT of the chosen partition.
  task automatic run_job(input logic [DW-1:0] thr, input logic [IW-1:0] mi, input int lat_max,
                         input bit stray, input bit busy_start, input int abort_it,
                         input int abort_part);
    int cyc, eng_it, eng_part, cur, cnt;
    bit pending, abort_next;
    r_cycles = 0; r_swaps = 0; r_starts = 0; r_seq_err = 0; r_overlap = 0; r_busy_err = 0;
    r_timeout = 1'b0; r_aborted = 1'b0;
    cyc = 0; eng_it = 0; eng_part = 0; cur = 0; cnt = 0; pending = 1'b0; abort_next = 1'b0;
    @(negedge clk);
    bus.threshold = thr;
    bus.max_iter  = mi;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.threshold = $urandom;
    bus.max_iter  = IW'($urandom);
    r_first_iter  = bus.iteration_number;
    forever begin
      if (abort_next) begin
        rst = 1'b1;
        r_aborted = 1'b1;
        break;
      end
      if (bus.pagerank_complete === 1'b1) break;
      if (cyc > 4000) begin
        r_timeout = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) r_busy_err++;
      if (bus.part_start === 1'b1 && bus.swap_buffers === 1'b1) r_overlap++;
      bus.part_done  = 1'b0;
      bus.part_delta = $urandom;
      bus.start      = busy_start && (cyc == 5);
      if (bus.swap_buffers === 1'b1) begin
        r_swaps++;
        eng_it++;
        eng_part = 0;
      end
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          pending = 1'b0;
          bus.part_done  = 1'b1;
          bus.part_delta = tab[(eng_it > 7) ? 7 : eng_it][(cur < NP) ? cur : 0];
        end
      end
      if (bus.part_start === 1'b1) begin
        r_starts++;
        if (bus.part_id !== PW'(eng_part)) r_seq_err++;
        cur = eng_part;
        eng_part++;
        if (eng_it == abort_it && cur == abort_part) begin
          abort_next = 1'b1;
        end else begin
          pending = 1'b1;
          cnt = $urandom_range(1, lat_max);
        end
        if (stray) begin
          bus.part_done  = 1'b1;
          bus.part_delta = '1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    r_cycles = cyc;
    bus.part_done = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.part_start, bus.swap_buffers, bus.busy, bus.pagerank_complete, bus.converged} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {bus.part_start, bus.swap_buffers, bus.busy, bus.pagerank_complete, bus.converged});
    end
    checks++;
    if (bus.part_id !== '0 || bus.iteration_number !== '0) begin
      failures++;
      $display("[TB] FAIL reset_counters: got part_id=%0d iter=%0d expected 0/0", bus.part_id, bus.iteration_number);
    end
    checks++;
    if (bus.delta !== '0) begin
      failures++;
      $display("[TB] FAIL reset_delta: got %0d expected 0", bus.delta);
    end
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.part_start !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL idle_no_issue: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_convergence();
    for (int it = 0; it < 8; it++) for (int p = 0; p < NP; p++) tab[it][p] = '0;
    tab[0][0] = 32'd15;
    run_job(32'd10, 16'd100, 1, 1'b0, 1'b0, -1, -1);
    checks++;
    if (r_timeout !== 1'b0 || bus.pagerank_complete !== 1'b1 || bus.converged !== 1'b1) begin
      failures++;
      $display("[TB] FAIL conv_status: got timeout=%0d complete=%0d converged=%0d expected 0/1/1",
               r_timeout, bus.pagerank_complete, bus.converged);
    end
    checks++;
    if (bus.iteration_number !== 16'd1 || bus.delta !== 32'd0) begin
      failures++;
      $display("[TB] FAIL conv_result: got iter=%0d delta=%0d expected 1/0", bus.iteration_number, bus.delta);
    end
    checks++;
    if (r_swaps !== 1) begin
      failures++;
      $display("[TB] FAIL conv_swaps: got %0d expected 1", r_swaps);
    end
    checks++;
    if (r_cycles !== 47) begin
      failures++;
      $display("[TB] FAIL conv_latency: got %0d expected 47", r_cycles);
    end
  endtask

  task automatic test_iteration_limit();
    for (int it = 0; it < 8; it++) for (int p = 0; p < NP; p++) tab[it][p] = 32'd1;
    run_job(32'd0, 16'd3, 1, 1'b0, 1'b0, -1, -1);
    checks++;
    if (bus.converged !== 1'b0 || bus.iteration_number !== 16'd2 || bus.delta !== 32'd11) begin
      failures++;
      $display("[TB] FAIL limit_result: got conv=%0d iter=%0d delta=%0d expected 0/2/11",
               bus.converged, bus.iteration_number, bus.delta);
    end
    checks++;
    if (r_swaps !== 2 || r_starts !== 33) begin
      failures++;
      $display("[TB] FAIL limit_pulses: got swaps=%0d starts=%0d expected 2/33", r_swaps, r_starts);
    end
    checks++;
    if (r_cycles !== 71 || r_overlap !== 0) begin
      failures++;
      $display("[TB] FAIL limit_timing: got cycles=%0d overlap=%0d expected 71/0", r_cycles, r_overlap);
    end
  endtask

  task automatic test_protocol();
    for (int it = 0; it < 8; it++) for (int p = 0; p < NP; p++) tab[it][p] = 32'd3;
    run_job(32'd0, 16'd0, 1, 1'b1, 1'b1, -1, -1);
    checks++;
    if (bus.pagerank_complete !== 1'b1 || bus.converged !== 1'b0 || bus.iteration_number !== 16'd0) begin
      failures++;
      $display("[TB] FAIL proto_status: got complete=%0d conv=%0d iter=%0d expected 1/0/0",
               bus.pagerank_complete, bus.converged, bus.iteration_number);
    end
    checks++;
    if (bus.delta !== 32'd33) begin
      failures++;
      $display("[TB] FAIL proto_delta: got %0d expected 33", bus.delta);
    end
    checks++;
    if (r_starts !== NP || r_swaps !== 0 || r_cycles !== 23 || r_busy_err !== 0) begin
      failures++;
      $display("[TB] FAIL proto_flow: got starts=%0d swaps=%0d cycles=%0d busy_err=%0d expected 11/0/23/0",
               r_starts, r_swaps, r_cycles, r_busy_err);
    end
  endtask

  task automatic test_done_hold();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.part_done  = 1'b1;
    bus.part_delta = 32'h0000_FFFF;
    repeat (6) begin
      @(negedge clk);
      bus.part_done = 1'b0;
      if (bus.pagerank_complete !== 1'b1 || bus.converged !== 1'b0 || bus.iteration_number !== 16'd0 ||
          bus.delta !== 32'd33 || bus.busy !== 1'b0 || bus.part_start !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL done_hold: got %0d unstable cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    for (int it = 0; it < 8; it++) for (int p = 0; p < NP; p++) tab[it][p] = 32'd1;
    run_job(32'd0, 16'd5, 1, 1'b0, 1'b0, 2, 4);
    checks++;
    if (r_aborted !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_reached: got %0d expected 1", r_aborted);
    end
    @(negedge clk);
    checks++;
    if ({bus.part_start, bus.swap_buffers, bus.busy, bus.pagerank_complete, bus.converged} !== 5'b0 ||
        bus.part_id !== '0 || bus.iteration_number !== '0 || bus.delta !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got flags=%b part_id=%0d iter=%0d delta=%0d expected all 0",
               {bus.part_start, bus.swap_buffers, bus.busy, bus.pagerank_complete, bus.converged},
               bus.part_id, bus.iteration_number, bus.delta);
    end
    rst = 1'b0;
    bus.part_done  = 1'b1;
    bus.part_delta = 32'd7;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      bus.part_done = 1'b0;
      if (bus.part_start !== 1'b0 || bus.busy !== 1'b0 || bus.part_id !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL midreset_late_done: got %0d active cycles expected 0", bad);
    end
    run_job(32'd0, 16'd2, 1, 1'b0, 1'b0, -1, -1);
    checks++;
    if (r_first_iter !== 16'd0 || r_seq_err !== 0 || r_starts !== 22 || r_swaps !== 1) begin
      failures++;
      $display("[TB] FAIL midreset_restart: got iter0=%0d seq_err=%0d starts=%0d swaps=%0d expected 0/0/22/1",
               r_first_iter, r_seq_err, r_starts, r_swaps);
    end
    checks++;
    if (bus.iteration_number !== 16'd1 || bus.delta !== 32'd11 || bus.converged !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_result: got iter=%0d delta=%0d conv=%0d expected 1/11/0",
               bus.iteration_number, bus.delta, bus.converged);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] d [2][3];
    logic [7:0] exp_d [2];
    bit         exp_c [2];
    int         cyc, p;
    bit         pend;
    d[0] = '{8'd200, 8'd200, 8'd0};
    d[1] = '{8'd100, 8'd54, 8'd100};
    exp_d[0] = 8'd255; exp_c[0] = 1'b0;
    exp_d[1] = 8'd254; exp_c[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus8.threshold = 8'd255;
      bus8.max_iter  = 4'd1;
      bus8.start     = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      cyc = 0; p = 0; pend = 1'b0;
      while (bus8.pagerank_complete !== 1'b1 && cyc < 200) begin
        bus8.part_done  = 1'b0;
        bus8.part_delta = 8'($urandom);
        if (pend) begin
          bus8.part_done  = 1'b1;
          bus8.part_delta = d[c][(p < 3) ? p : 0];
          pend = 1'b0;
          p++;
        end else if (bus8.part_start === 1'b1) begin
          pend = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
      bus8.part_done = 1'b0;
      checks++;
      if (cyc >= 200) begin
        failures++;
        $display("[TB] FAIL sat_timeout case %0d: got %0d cycles expected < 200", c, cyc);
      end
      checks++;
      if (bus8.delta !== exp_d[c] || bus8.converged !== exp_c[c]) begin
        failures++;
        $display("[TB] FAIL sat_result case %0d: got delta=%0d conv=%0d expected %0d/%0d",
                 c, bus8.delta, bus8.converged, exp_d[c], exp_c[c]);
      end
    end
  endtask

  // Consecutive random runs, each restarted straight from DONE.
  task automatic test_back_to_back();
    logic [DW-1:0] thr;
    logic [IW-1:0] mi;
    int            lat;
    bit            stray;
    for (int run = 0; run < 10; run++) begin
      thr   = $urandom_range(0, 140);
      mi    = IW'($urandom_range(0, 6));
      lat   = $urandom_range(1, 3);
      stray = 1'($urandom_range(0, 1));
      for (int it = 0; it < 8; it++)
        for (int p = 0; p < NP; p++)
          tab[it][p] = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h8000_0000) : $urandom_range(0, 15);
      model_run(thr, mi);
      run_job(thr, mi, lat, stray, 1'b0, -1, -1);
      checks++;
      if (r_timeout !== 1'b0 || bus.converged !== m_conv || int'(bus.iteration_number) !== m_iter) begin
        failures++;
        $display("[TB] FAIL rand_status run %0d: got timeout=%0d conv=%0d iter=%0d expected 0/%0d/%0d",
                 run, r_timeout, bus.converged, bus.iteration_number, m_conv, m_iter);
      end
      checks++;
      if (bus.delta !== m_delta) begin
        failures++;
        $display("[TB] FAIL rand_delta run %0d: got %0d expected %0d", run, bus.delta, m_delta);
      end
      checks++;
      if (r_swaps !== m_iter || r_starts !== (m_iter + 1) * NP || r_seq_err !== 0 || r_overlap !== 0 ||
          r_busy_err !== 0) begin
        failures++;
        $display("[TB] FAIL rand_flow run %0d: got swaps=%0d starts=%0d seq_err=%0d overlap=%0d busy_err=%0d expected %0d/%0d/0/0/0",
                 run, r_swaps, r_starts, r_seq_err, r_overlap, r_busy_err, m_iter, (m_iter + 1) * NP);
      end
      if (lat == 1) begin
        checks++;
        if (r_cycles !== (m_iter + 1) * (2 * NP + 2) - 1) begin
          failures++;
          $display("[TB] FAIL rand_latency run %0d: got %0d expected %0d",
                   run, r_cycles, (m_iter + 1) * (2 * NP + 2) - 1);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.start = 1'b0;  bus.threshold = '0;  bus.max_iter = '0;  bus.part_done = 1'b0;  bus.part_delta = '0;
    bus8.start = 1'b0; bus8.threshold = '0; bus8.max_iter = '0; bus8.part_done = 1'b0; bus8.part_delta = '0;
    $display("[TB] starting");
    test_reset();
    test_convergence();
    test_iteration_limit();
    test_protocol();
    test_done_hold();
    test_reset_mid_wait();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
